// File: rtl/accum16_pkg.sv
// Shared constants and the FSM state type for the accum16 accumulator slice.
package accum16_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/adder16.sv
// Team 16-bit ripple-carry adder; no carry-in and no carry-out port.
module adder16
  import accum16_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] c;

  assign c[0] = 1'b0;

  // The carry out of the top bit is never produced, which keeps the chain free of dangling nets.
  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    if (i < DATA_W - 1) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

endmodule

// File: rtl/accum16.sv
// Accumulates a programmed-length stream of 16-bit operands through adder16.
// Returns the wrapped total and a sticky unsigned-overflow flag over a valid/ready handshake.
module accum16
  import accum16_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] sum;
  logic              ovf;
  logic [LEN_W-1:0]  remaining;
  logic              beat;
  logic              carry;
  logic              last_beat;

  adder16 u_add (
    .a   (acc),
    .b   (in_data),
    .sum (sum)
  );

  assign beat      = in_valid & in_ready;
  // The adder has no carry-out, so a wrap is detected by the result falling below the old total.
  assign carry     = (sum < acc);
  assign last_beat = beat && (remaining == LEN_W'(1));

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_sum   = out_valid ? acc : '0;
  assign out_ovf   = out_valid & ovf;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (last_beat) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else if ((state == S_IDLE) && start) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= len;
    end else if (beat) begin
      acc       <= sum;
      ovf       <= ovf | carry;
      remaining <= remaining - LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_accum16.sv
// Self-checking bench for accum16: directed scenarios plus randomized streams
// compared against a plain-arithmetic model of the expected total and overflow.
module tb_accum16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_ovf;
  logic        busy;

  int checks;
  int failures;

  logic [15:0] ops[$];

  accum16 #(.LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // True total over the whole stream: the low 16 bits are the wrapped sum, and any wrap
  // along the way happens exactly when the true total reaches 2^16.
  task automatic model(input int n, output logic [15:0] s, output logic o);
    longint total;
    total = 0;
    for (int i = 0; i < n; i++) total += longint'(ops[i]);
    s = total[15:0];
    o = (total > 64'd65535);
  endtask

  // Called in a negedge slot with the DUT idle; returns once out_valid is seen (out_ready left low).
  task automatic run_stream(input int n, input bit gaps, output logic [15:0] s, output logic o,
                            output int beats, output int lat, output int rdy_cnt);
    int cyc;
    int last;
    beats   = 0;
    lat     = -1;
    last    = 0;
    rdy_cnt = 0;
    start    = 1'b1;
    len      = n[7:0];
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < 300) begin
      if (out_valid) begin
        lat = cyc;
        break;
      end
      if (beats < n) in_valid = gaps ? ($urandom_range(0, 2) == 0) : 1'b1;
      else           in_valid = 1'b0;
      in_data = in_valid ? ops[beats] : 16'($urandom);
      #1;
      if (in_ready) rdy_cnt++;
      if (in_valid && in_ready) begin
        beats++;
        last = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (lat >= 0) lat = lat - last;
    s = out_sum;
    o = out_ovf;
  endtask

  task automatic finish_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got rdy=%b vld=%b busy=%b expected 0 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (out_sum !== 16'h0000 || out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_data: got sum=%h ovf=%b expected 0000 0", out_sum, out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] s, es;
    logic o, eo;
    int beats, lat, rdy;
    ops = {16'd1, 16'd2, 16'd3, 16'd4};
    model(4, es, eo);
    run_stream(4, 1'b0, s, o, beats, lat, rdy);
    checks++;
    if (s !== es || s !== 16'd10 || o !== eo) begin
      failures++;
      $display("[TB] FAIL basic_sum: got %h/%b expected %h/%b", s, o, es, eo);
    end
    checks++;
    if (lat !== 1 || beats !== 4 || rdy !== 4) begin
      failures++;
      $display("[TB] FAIL basic_timing: got lat=%0d beats=%0d rdy=%0d expected 1 4 4", lat, beats, rdy);
    end
    finish_result();
  endtask

  task automatic test_overflow();
    logic [15:0] s, es;
    logic o, eo;
    int beats, lat, rdy;
    ops = {16'hFFFF, 16'h0002};
    model(2, es, eo);
    run_stream(2, 1'b0, s, o, beats, lat, rdy);
    checks++;
    if (s !== es || s !== 16'h0001 || o !== eo || o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_sum: got %h/%b expected %h/%b", s, o, es, eo);
    end
    finish_result();
    ops = {16'd5};
    model(1, es, eo);
    run_stream(1, 1'b0, s, o, beats, lat, rdy);
    checks++;
    if (s !== es || o !== eo || o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_cleared: got %h/%b expected %h/%b", s, o, es, eo);
    end
    finish_result();
  endtask

  task automatic test_gaps();
    logic [15:0] s, es;
    logic o, eo;
    int beats, lat, rdy;
    ops = {16'h1000, 16'h1000, 16'h1000};
    model(3, es, eo);
    run_stream(3, 1'b1, s, o, beats, lat, rdy);
    checks++;
    if (beats !== 3 || s !== es || s !== 16'h3000 || o !== eo) begin
      failures++;
      $display("[TB] FAIL gaps: got beats=%0d sum=%h ovf=%b expected 3 %h %b", beats, s, o, es, eo);
    end
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("[TB] FAIL gaps_latency: got %0d expected 1", lat);
    end
    finish_result();
  endtask

  task automatic test_hold_and_back_to_back();
    logic [15:0] s, es;
    logic o, eo;
    int beats, lat, rdy;
    ops = {16'hC000, 16'h8000, 16'h0123};
    model(3, es, eo);
    run_stream(3, 1'b0, s, o, beats, lat, rdy);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len   = 8'($urandom_range(0, 255));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== es || out_ovf !== eo) begin
        failures++;
        $display("[TB] FAIL hold_stable: cycle %0d got vld=%b sum=%h ovf=%b expected 1 %h %b",
                 i, out_valid, out_sum, out_ovf, es, eo);
      end
    end
    start = 1'b0;
    finish_result();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_release: got vld=%b busy=%b rdy=%b expected 0 0 0", out_valid, busy, in_ready);
    end
    ops = {16'h0042, 16'h0100};
    model(2, es, eo);
    run_stream(2, 1'b0, s, o, beats, lat, rdy);
    checks++;
    if (s !== es || o !== eo || lat !== 1) begin
      failures++;
      $display("[TB] FAIL back_to_back: got %h/%b lat=%0d expected %h/%b lat=1", s, o, lat, es, eo);
    end
    finish_result();
  endtask

  task automatic test_len_zero();
    logic [15:0] s;
    logic o;
    int beats, lat, rdy;
    ops = {};
    run_stream(0, 1'b0, s, o, beats, lat, rdy);
    checks++;
    if (lat !== 1 || s !== 16'h0000 || o !== 1'b0 || rdy !== 0) begin
      failures++;
      $display("[TB] FAIL len_zero: got lat=%0d sum=%h ovf=%b rdy=%0d expected 1 0000 0 0", lat, s, o, rdy);
    end
    finish_result();
  endtask

  task automatic test_reset_mid();
    logic [15:0] s, es;
    logic o, eo;
    int beats, lat, rdy;
    start = 1'b1;
    len   = 8'd5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0011;
    @(negedge clk);
    in_data  = 16'h0022;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 16'h0000 || out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid: got rdy=%b vld=%b busy=%b sum=%h ovf=%b expected all 0",
               in_ready, out_valid, busy, out_sum, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ops = {16'd7};
    model(1, es, eo);
    run_stream(1, 1'b0, s, o, beats, lat, rdy);
    checks++;
    if (s !== es || s !== 16'd7 || o !== eo) begin
      failures++;
      $display("[TB] FAIL reset_restart: got %h/%b expected %h/%b", s, o, es, eo);
    end
    finish_result();
  endtask

  task automatic test_random();
    logic [15:0] s, es;
    logic o, eo;
    int beats, lat, rdy, n;
    for (int t = 0; t < 15; t++) begin
      n = $urandom_range(0, 12);
      ops = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) ops.push_back(16'($urandom_range(16'hC000, 16'hFFFF)));
        else                           ops.push_back(16'($urandom_range(0, 16'h0FFF)));
      end
      model(n, es, eo);
      run_stream(n, bit'($urandom_range(0, 1)), s, o, beats, lat, rdy);
      checks++;
      if (s !== es || o !== eo || beats !== n || lat !== 1) begin
        failures++;
        $display("[TB] FAIL random_%0d: got sum=%h ovf=%b beats=%0d lat=%0d expected %h %b %0d 1",
                 t, s, o, beats, lat, es, eo, n);
      end
      finish_result();
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_overflow();
    test_gaps();
    test_hold_and_back_to_back();
    test_len_zero();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
